med_dose_scheduler: RTL and testbench
=====================================

// Module: med_dose_scheduler
// PURPOSE
// - Multi-medicine dose scheduler. Owns the shared time-remaining RAM and the timer tick for NSLOT medicine slots.
// - Sits between the front-end (passcode, ROM and frequency entry) and the RAM/LED/timer blocks.
// - On each Tick it scans every active slot: read, decrement, write back; raises a per-slot alarm at zero.
// - Also serialises configuration writes against the scan so the RAM has exactly one master.
// PARAMETERS
// - NSLOT       4   number of medicine slots; RAM depth used.
// - ADDR_W      2   slot/RAM address width; must be >= clog2(NSLOT).
// - CNT_W       5   width of the time-remaining and period fields.
// - MAX_PERIOD  24  period saturation value, in ticks.
// PORTS
// - Clk        in   1       clock.
// - Rst        in   1       reset: synchronous, active-low.
// - Tick       in   1       1-cycle pulse from the timer (1 s or 1 min).
// - Cfg_Valid  in   1       config request; held until accepted.
// - Cfg_Ready  out  1       config accepted on a cycle where Cfg_Valid && Cfg_Ready.
// - Cfg_Slot   in   ADDR_W  slot being configured.
// - Cfg_Period in   CNT_W   ticks between doses; 0 = disable slot.
// - Ack        in   1       1-cycle pulse: clear the alarm of Ack_Slot.
// - Ack_Slot   in   ADDR_W  slot being acknowledged.
// - Ram_Addr   out  ADDR_W  RAM address.
// - Ram_Ren    out  1       read strobe; data is valid on Ram_RData 1 cycle later.
// - Ram_Wen    out  1       write strobe.
// - Ram_WData  out  CNT_W   write data.
// - Ram_RData  in   CNT_W   read data.
// - Alarm_Vec  out  NSLOT   per-slot dose-due flags.
// - LED_Out    out  4       4'b1111 when any alarm is set, else 4'b0000.
// - Busy       out  1       high while a scan or config write is in progress.
// - Overrun    out  1       sticky: a Tick was dropped.
// BEHAVIOUR
// - Reset (Rst==0 at a Clk edge):
//   - State IDLE; all period/active/alarm registers 0; tick_pend 0.
//   - Outputs 0 except Cfg_Ready=1; Overrun cleared.
//   - RAM contents are not touched. Reset mid-scan aborts the scan with no write.
// - State machine: IDLE, CFG_WR, RD, RWAIT, WR, NEXT.
// - IDLE:
//   - Tick or tick_pend set -> RD with slot=0; tick_pend cleared.
//   - Otherwise, accepted config -> CFG_WR.
//   - A tick always wins over a config request.
// - CFG_WR (1 cycle):
//   - Period p = min(Cfg_Period, MAX_PERIOD).
//   - Ram_Wen=1, Ram_WData=p; period[slot]=p; active[slot]=(p!=0); alarm[slot] cleared. Next state IDLE.
// - Cfg_Ready=1 only in IDLE with no tick pending and no Tick this cycle.
// - RD:
//   - Inactive slot: skip to NEXT, 1 cycle, no RAM access.
//   - Active slot: Ram_Ren=1, Ram_Addr=slot, then RWAIT.
// - RWAIT: capture Ram_RData as r, then WR.
// - WR: Ram_Wen=1. If r<=1: write period[slot] and set alarm[slot]. Else write r-1. No wrap below 0.
// - NEXT: last slot (slot==NSLOT-1) -> IDLE; else slot+1 -> RD.
// - Scan cost: 3 cycles per active slot, 1 per inactive slot, plus 1 NEXT cycle per slot.
// - Tick during a scan sets tick_pend (1 deep). Tick while tick_pend is already set -> dropped, Overrun=1.
// - Ack clears alarm[Ack_Slot] in any state. Ack and an alarm set on the same slot in the same cycle -> set wins.
// - Alarm_Vec and LED_Out are registered and follow alarm[] with 1 cycle of latency.
// CONFIGURATION
// - MISSED_DOSE_CNT_EN defined:
//   - Adds a per-slot 4-bit saturating missed-dose counter.
//   - Counter increments in WR when an alarm is set while alarm[slot] is already 1.
//   - Extra ports: Miss_Sel in ADDR_W, Miss_Count out 4 (combinational read of the selected counter).
//   - Counter is cleared by CFG_WR of that slot and by reset.
// - MISSED_DOSE_CNT_EN undefined: no counters and no extra ports; all other behaviour identical.
// STRUCTURE
// - med_pkg: state enum, CNT_W/ADDR_W defaults, MAX_PERIOD, LED_ALARM=4'b1111, LED_OFF=4'b0000.
// - Sub-module med_slot_regs: holds the period/active/alarm arrays (and the missed-dose counters when enabled).
//   - Inputs: one write port, alarm set and clear ports.
// - The top level holds the FSM, the RAM master and the tick pending/overrun logic.
// TESTING
// - Reset, then config slot 2, period 3 -> one Ram_Wen at addr 2 with data 3; active[2]=1; Cfg_Ready back to 1 the next cycle.
// - Slot 2 period 3, Ticks 1, 2, 3 -> RAM[2] goes 2, 1, then 3 with Alarm_Vec=4'b0100 and LED_Out=4'b1111.
// - Ack with Ack_Slot=2 while the alarm is set -> Alarm_Vec=0 and LED_Out=0 one cycle later; RAM unchanged.
// - Two Ticks during one 4-active-slot scan -> one extra scan runs and Overrun=1; a single Tick -> one rescan, Overrun=0.
// - Cfg_Period=30 -> RAM and period are written as 24. Cfg_Period=0 on an alarmed slot -> alarm cleared, slot skipped in later scans.
// - MISSED_DOSE_CNT_EN, period 1, no Ack for 20 Ticks -> Miss_Count saturates at 15.

Source files
------------

// File: rtl/med_pkg.sv
// -----------------------------------------------------------------------------
// med_pkg
// Shared types and constants for the medicine dose scheduler.
//   state_t         scheduler FSM states
//   *_DEF           default slot count, address width, counter width and
//                   period saturation value
//   LED_ALARM/OFF   LED patterns for "any dose due" and "nothing due"
// -----------------------------------------------------------------------------
package med_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG_WR = 3'd1,
        RD     = 3'd2,
        RWAIT  = 3'd3,
        WR     = 3'd4,
        NEXT   = 3'd5
    } state_t;

    localparam int NSLOT_DEF      = 4;
    localparam int ADDR_W_DEF     = 2;
    localparam int CNT_W_DEF      = 5;
    localparam int MAX_PERIOD_DEF = 24;

    localparam logic [3:0] LED_ALARM = 4'b1111;
    localparam logic [3:0] LED_OFF   = 4'b0000;

endpackage

// File: rtl/med_dose_scheduler_if.sv
// -----------------------------------------------------------------------------
// med_dose_scheduler_if
// Configuration channel from the front-end (passcode / ROM / frequency entry)
// into the dose scheduler.
//   Cfg_Valid   request present; held with stable Cfg_Slot/Cfg_Period until
//               accepted
//   Cfg_Ready   scheduler can take the request this cycle
//   Cfg_Slot    slot being configured
//   Cfg_Period  ticks between doses, 0 disables the slot
// Handshake: a request transfers on exactly the cycles where Cfg_Valid and
// Cfg_Ready are both high at the rising clock edge; Cfg_Ready never depends
// on Cfg_Valid, and the requester must not drop or change a request before
// it has transferred.
// modports: master = front-end, slave = scheduler.
// -----------------------------------------------------------------------------
interface med_dose_scheduler_if #(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 5
);
    logic              Cfg_Valid;
    logic              Cfg_Ready;
    logic [ADDR_W-1:0] Cfg_Slot;
    logic [CNT_W-1:0]  Cfg_Period;

    modport master (output Cfg_Valid, output Cfg_Slot, output Cfg_Period, input Cfg_Ready);
    modport slave  (input Cfg_Valid, input Cfg_Slot, input Cfg_Period, output Cfg_Ready);
endinterface

// File: rtl/med_slot_regs.sv
// -----------------------------------------------------------------------------
// med_slot_regs
// Per-slot period / active / alarm registers for the dose scheduler.
// Optional feature macro: MISSED_DOSE_CNT_EN adds a 4-bit saturating
// missed-dose counter per slot plus a combinational read port.
//   Clk, Rst             clock, synchronous active-low reset
//   wr_en/slot/period    configuration write: loads period, derives active,
//                        clears alarm (and the missed-dose counter)
//   set_en/set_slot      raise the alarm of a slot (dose due)
//   clr_en/clr_slot      clear the alarm of a slot (acknowledge)
//   period/active/alarm  register contents
//   miss_sel/miss_count  (MISSED_DOSE_CNT_EN only) counter read port
// A set beats a clear on the same slot in the same cycle.
// -----------------------------------------------------------------------------
module med_slot_regs
    import med_pkg::*;
#(
    parameter int NSLOT  = NSLOT_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_slot,
    input  logic [CNT_W-1:0]            wr_period,
    input  logic                        set_en,
    input  logic [ADDR_W-1:0]           set_slot,
    input  logic                        clr_en,
    input  logic [ADDR_W-1:0]           clr_slot,
    output logic [NSLOT-1:0][CNT_W-1:0] period,
    output logic [NSLOT-1:0]            active,
    output logic [NSLOT-1:0]            alarm
`ifdef MISSED_DOSE_CNT_EN
    ,
    input  logic [ADDR_W-1:0]           miss_sel,
    output logic [3:0]                  miss_count
`endif
);

`ifdef MISSED_DOSE_CNT_EN
    logic [NSLOT-1:0][3:0] miss;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            period <= '0;
            active <= '0;
            alarm  <= '0;
`ifdef MISSED_DOSE_CNT_EN
            miss   <= '0;
`endif
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wr_en && wr_slot == ADDR_W'(i)) begin
                    period[i] <= wr_period;
                    active[i] <= (wr_period != '0);
                end
                if (set_en && set_slot == ADDR_W'(i)) begin
                    alarm[i] <= 1'b1;
                end else if ((clr_en && clr_slot == ADDR_W'(i)) ||
                             (wr_en && wr_slot == ADDR_W'(i))) begin
                    alarm[i] <= 1'b0;
                end
`ifdef MISSED_DOSE_CNT_EN
                // A new due-point while the previous one is still unacknowledged
                // counts as a missed dose.
                if (wr_en && wr_slot == ADDR_W'(i)) begin
                    miss[i] <= 4'd0;
                end else if (set_en && set_slot == ADDR_W'(i) && alarm[i] &&
                             miss[i] != 4'hF) begin
                    miss[i] <= miss[i] + 4'd1;
                end
`endif
            end
        end
    end

`ifdef MISSED_DOSE_CNT_EN
    always_comb begin
        miss_count = 4'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (miss_sel == ADDR_W'(i)) miss_count = miss[i];
        end
    end
`endif

endmodule

// File: rtl/med_dose_scheduler.sv
// -----------------------------------------------------------------------------
// med_dose_scheduler
// Owns the time-remaining RAM and the timer tick for NSLOT medicine slots.
// On every Tick it walks all slots; each active slot is read, decremented and
// written back, and reloads its period with an alarm when it reaches zero.
// Configuration writes are serialised against the scan so the RAM has a
// single master. Optional feature macro: MISSED_DOSE_CNT_EN (adds Miss_Sel /
// Miss_Count and per-slot missed-dose counters).
//   Clk, Rst        clock, synchronous active-low reset
//   Tick            1-cycle timer pulse
//   cfg             configuration channel (slave modport)
//   Ack, Ack_Slot   1-cycle pulse clearing the alarm of Ack_Slot
//   Ram_*           RAM master port, read data valid 1 cycle after Ram_Ren
//   Alarm_Vec       registered per-slot dose-due flags
//   LED_Out         registered: LED_ALARM when any alarm is set
//   Busy            scan or configuration write in progress
//   Overrun         sticky: a Tick was dropped
//   Dbg_State       current FSM state
// -----------------------------------------------------------------------------
module med_dose_scheduler
    import med_pkg::*;
#(
    parameter int NSLOT      = NSLOT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_PERIOD = MAX_PERIOD_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Tick,
    med_dose_scheduler_if.slave  cfg,
    input  logic                 Ack,
    input  logic [ADDR_W-1:0]    Ack_Slot,
    output logic [ADDR_W-1:0]    Ram_Addr,
    output logic                 Ram_Ren,
    output logic                 Ram_Wen,
    output logic [CNT_W-1:0]     Ram_WData,
    input  logic [CNT_W-1:0]     Ram_RData,
    output logic [NSLOT-1:0]     Alarm_Vec,
    output logic [3:0]           LED_Out,
    output logic                 Busy,
    output logic                 Overrun,
    output state_t               Dbg_State
`ifdef MISSED_DOSE_CNT_EN
    ,
    input  logic [ADDR_W-1:0]    Miss_Sel,
    output logic [3:0]           Miss_Count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NSLOT - 1);
    localparam logic [CNT_W-1:0]  MAX_P     = CNT_W'(MAX_PERIOD);

    state_t                     state, state_nxt;
    logic [ADDR_W-1:0]          slot;
    logic [CNT_W-1:0]           r_q;
    logic [ADDR_W-1:0]          cfg_slot_q;
    logic [CNT_W-1:0]           cfg_p_q;
    logic                       tick_pend;
    logic                       set_en;
    logic                       cfg_fire;
    logic [CNT_W-1:0]           sat_period;
    logic [NSLOT-1:0][CNT_W-1:0] period;
    logic [NSLOT-1:0]           active;
    logic [NSLOT-1:0]           alarm;
    logic [CNT_W-1:0]           cur_period;
    logic                       cur_active;

    // A pending or arriving tick blocks configuration so ticks always win.
    assign cfg.Cfg_Ready = (state == IDLE) && !tick_pend && !Tick;
    assign cfg_fire      = cfg.Cfg_Valid && cfg.Cfg_Ready;
    assign sat_period    = (cfg.Cfg_Period > MAX_P) ? MAX_P : cfg.Cfg_Period;
    assign Busy          = (state != IDLE);
    assign Dbg_State     = state;

    always_comb begin
        cur_period = '0;
        cur_active = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot == ADDR_W'(i)) begin
                cur_period = period[i];
                cur_active = active[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        Ram_Addr  = '0;
        Ram_Ren   = 1'b0;
        Ram_Wen   = 1'b0;
        Ram_WData = '0;
        set_en    = 1'b0;
        case (state)
            IDLE: begin
                if (Tick || tick_pend) state_nxt = RD;
                else if (cfg_fire)     state_nxt = CFG_WR;
            end
            CFG_WR: begin
                Ram_Addr  = cfg_slot_q;
                Ram_Wen   = 1'b1;
                Ram_WData = cfg_p_q;
                state_nxt = IDLE;
            end
            RD: begin
                if (cur_active) begin
                    Ram_Ren   = 1'b1;
                    Ram_Addr  = slot;
                    state_nxt = RWAIT;
                end else begin
                    state_nxt = NEXT;
                end
            end
            RWAIT: state_nxt = WR;
            WR: begin
                Ram_Wen  = 1'b1;
                Ram_Addr = slot;
                // 1 means this tick is the due-point; 0 is treated the same so
                // the counter can never wrap.
                if (r_q <= CNT_W'(1)) begin
                    Ram_WData = cur_period;
                    set_en    = 1'b1;
                end else begin
                    Ram_WData = r_q - CNT_W'(1);
                end
                state_nxt = NEXT;
            end
            NEXT: state_nxt = (slot == LAST_SLOT) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= IDLE;
            slot       <= '0;
            r_q        <= '0;
            cfg_slot_q <= '0;
            cfg_p_q    <= '0;
            tick_pend  <= 1'b0;
            Overrun    <= 1'b0;
            Alarm_Vec  <= '0;
            LED_Out    <= LED_OFF;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                slot <= '0;
            end else if (state == NEXT && slot != LAST_SLOT) begin
                slot <= slot + ADDR_W'(1);
            end
            if (state == RWAIT) r_q <= Ram_RData;
            if (cfg_fire) begin
                cfg_slot_q <= cfg.Cfg_Slot;
                cfg_p_q    <= sat_period;
            end
            // IDLE consumes one tick; a second one arriving in that same cycle
            // stays pending rather than being lost.
            if (state == IDLE) begin
                tick_pend <= Tick && tick_pend;
            end else if (Tick) begin
                if (tick_pend) Overrun   <= 1'b1;
                else           tick_pend <= 1'b1;
            end
            Alarm_Vec <= alarm;
            LED_Out   <= (|alarm) ? LED_ALARM : LED_OFF;
        end
    end

    med_slot_regs #(
        .NSLOT  (NSLOT),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_slot_regs (
        .Clk        (Clk),
        .Rst        (Rst),
        .wr_en      (state == CFG_WR),
        .wr_slot    (cfg_slot_q),
        .wr_period  (cfg_p_q),
        .set_en     (set_en),
        .set_slot   (slot),
        .clr_en     (Ack),
        .clr_slot   (Ack_Slot),
        .period     (period),
        .active     (active),
        .alarm      (alarm)
`ifdef MISSED_DOSE_CNT_EN
        ,
        .miss_sel   (Miss_Sel),
        .miss_count (Miss_Count)
`endif
    );

endmodule

// File: tb/tb_med_dose_scheduler.sv
// -----------------------------------------------------------------------------
// tb_med_dose_scheduler
// Directed bench for med_dose_scheduler with a behavioural 1-cycle-latency RAM.
// A table of configuration vectors covers period saturation and disabling;
// hand-written sequences cover scan timing, alarms, acknowledge, tick
// pending/overrun and (with MISSED_DOSE_CNT_EN) missed-dose saturation.
// -----------------------------------------------------------------------------
module tb_med_dose_scheduler;
    import med_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Tick;
    logic        Ack;
    logic [1:0]  Ack_Slot;
    logic [1:0]  Ram_Addr;
    logic        Ram_Ren;
    logic        Ram_Wen;
    logic [4:0]  Ram_WData;
    logic [4:0]  Ram_RData;
    logic [3:0]  Alarm_Vec;
    logic [3:0]  LED_Out;
    logic        Busy;
    logic        Overrun;
    state_t      dbg_state;
`ifdef MISSED_DOSE_CNT_EN
    logic [1:0]  Miss_Sel;
    logic [3:0]  Miss_Count;
`endif

    logic [4:0]  ram [4];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [1:0] slot;
        logic [4:0] period;
        logic [4:0] exp_data;
    } cfg_vec_t;

    cfg_vec_t    tbl [7];

    med_dose_scheduler_if #(.ADDR_W(2), .CNT_W(5)) cfg_if ();

    med_dose_scheduler dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Tick       (Tick),
        .cfg        (cfg_if),
        .Ack        (Ack),
        .Ack_Slot   (Ack_Slot),
        .Ram_Addr   (Ram_Addr),
        .Ram_Ren    (Ram_Ren),
        .Ram_Wen    (Ram_Wen),
        .Ram_WData  (Ram_WData),
        .Ram_RData  (Ram_RData),
        .Alarm_Vec  (Alarm_Vec),
        .LED_Out    (LED_Out),
        .Busy       (Busy),
        .Overrun    (Overrun),
        .Dbg_State  (dbg_state)
`ifdef MISSED_DOSE_CNT_EN
        ,
        .Miss_Sel   (Miss_Sel),
        .Miss_Count (Miss_Count)
`endif
    );

    // clock / reset
    always #5 Clk = ~Clk;

    // behavioural RAM: registered read, write-first not needed
    always @(posedge Clk) begin
        if (Ram_Wen) ram[Ram_Addr] <= Ram_WData;
        if (Ram_Ren) Ram_RData <= ram[Ram_Addr];
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        Tick = 1'b0;
        Ack = 1'b0;
        cfg_if.Cfg_Valid = 1'b0;
        repeat (2) step();
        Rst = 1'b1;
    endtask

    task automatic pulse_tick();
        Tick = 1'b1;
        step();
        Tick = 1'b0;
    endtask

    // Offer a configuration, wait for acceptance, report the CFG_WR cycle's
    // RAM strobe and whether Cfg_Ready is back the cycle after.
    task automatic do_cfg(input logic [1:0] s, input logic [4:0] p,
                          output logic w, output logic [1:0] a,
                          output logic [4:0] d, output logic rdy);
        int n = 0;
        cfg_if.Cfg_Valid  = 1'b1;
        cfg_if.Cfg_Slot   = s;
        cfg_if.Cfg_Period = p;
        #1;
        while (!cfg_if.Cfg_Ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("cfg_accept_timeout", 0, 1);
        step();
        cfg_if.Cfg_Valid = 1'b0;
        w = Ram_Wen;
        a = Ram_Addr;
        d = Ram_WData;
        step();
        rdy = cfg_if.Cfg_Ready;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("idle_timeout", 0, 1);
    endtask

    task automatic tick_scan(output int n);
        pulse_tick();
        wait_idle(n);
    endtask

    initial begin
        logic       w;
        logic [1:0] a;
        logic [4:0] d;
        logic       rdy;
        int         n;

        Rst = 1'b0;
        Tick = 1'b0;
        Ack = 1'b0;
        Ack_Slot = 2'd0;
        cfg_if.Cfg_Valid = 1'b0;
        cfg_if.Cfg_Slot = 2'd0;
        cfg_if.Cfg_Period = 5'd0;
`ifdef MISSED_DOSE_CNT_EN
        Miss_Sel = 2'd0;
`endif

        tbl[0] = '{slot: 2'd1, period: 5'd30, exp_data: 5'd24};
        tbl[1] = '{slot: 2'd3, period: 5'd24, exp_data: 5'd24};
        tbl[2] = '{slot: 2'd0, period: 5'd25, exp_data: 5'd24};
        tbl[3] = '{slot: 2'd0, period: 5'd0,  exp_data: 5'd0};
        tbl[4] = '{slot: 2'd2, period: 5'd3,  exp_data: 5'd3};
        tbl[5] = '{slot: 2'd1, period: 5'd1,  exp_data: 5'd1};
        tbl[6] = '{slot: 2'd3, period: 5'd0,  exp_data: 5'd0};

        // reset state
        repeat (3) step();
        Rst = 1'b1;
        check("rst_cfg_ready", int'(cfg_if.Cfg_Ready), 1);
        check("rst_busy", int'(Busy), 0);
        check("rst_alarm_vec", int'(Alarm_Vec), 0);
        check("rst_led", int'(LED_Out), 0);
        check("rst_overrun", int'(Overrun), 0);
        check("rst_ram_wen", int'(Ram_Wen), 0);
        check("rst_ram_ren", int'(Ram_Ren), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));

        // configuration vectors
        for (int i = 0; i < 7; i++) begin
            do_cfg(tbl[i].slot, tbl[i].period, w, a, d, rdy);
            check($sformatf("cfg%0d_wen", i), int'(w), 1);
            check($sformatf("cfg%0d_addr", i), int'(a), int'(tbl[i].slot));
            check($sformatf("cfg%0d_wdata", i), int'(d), int'(tbl[i].exp_data));
            check($sformatf("cfg%0d_ready_back", i), int'(rdy), 1);
            check($sformatf("cfg%0d_ram", i), int'(ram[tbl[i].slot]), int'(tbl[i].exp_data));
        end

        // countdown on slot 2 with period 3; other slots inactive after reset
        do_reset();
        do_cfg(2'd2, 5'd3, w, a, d, rdy);
        check("s2_cfg_wen", int'(w), 1);
        check("s2_cfg_addr", int'(a), 2);
        check("s2_cfg_wdata", int'(d), 3);
        check("s2_cfg_ready_back", int'(rdy), 1);
        tick_scan(n);
        check("scan1_cycles", n, 10);
        check("tick1_ram2", int'(ram[2]), 2);
        check("tick1_alarm", int'(Alarm_Vec), 0);
        tick_scan(n);
        check("tick2_ram2", int'(ram[2]), 1);
        check("tick2_alarm", int'(Alarm_Vec), 0);
        tick_scan(n);
        check("tick3_ram2", int'(ram[2]), 3);
        check("tick3_alarm", int'(Alarm_Vec), 4);
        check("tick3_led", int'(LED_Out), 15);
        check("tick3_ram1_skipped", int'(ram[1]), 1);

        // acknowledge: Alarm_Vec follows one cycle after the alarm clears
        Ack = 1'b1;
        Ack_Slot = 2'd2;
        step();
        Ack = 1'b0;
        check("ack_latency_alarm", int'(Alarm_Vec), 4);
        step();
        check("ack_alarm", int'(Alarm_Vec), 0);
        check("ack_led", int'(LED_Out), 0);
        check("ack_ram2", int'(ram[2]), 3);

        // ack landing on the same cycle as an alarm set: set wins
        tick_scan(n);
        tick_scan(n);
        check("pre_set_ram2", int'(ram[2]), 1);
        pulse_tick();
        n = 0;
        while (!Ram_Wen && n < 50) begin
            step();
            n++;
        end
        check("set_wr_seen", int'(n < 50), 1);
        check("set_wr_addr", int'(Ram_Addr), 2);
        check("set_wr_data", int'(Ram_WData), 3);
        Ack = 1'b1;
        Ack_Slot = 2'd2;
        step();
        Ack = 1'b0;
        wait_idle(n);
        step();
        check("set_wins_alarm", int'(Alarm_Vec), 4);

        // tick beats a simultaneous config request
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Slot = 2'd2;
        cfg_if.Cfg_Period = 5'd0;
        Tick = 1'b1;
        #1;
        check("tick_blocks_ready", int'(cfg_if.Cfg_Ready), 0);
        step();
        Tick = 1'b0;
        check("tick_wins_state", int'(dbg_state), int'(RD));
        check("tick_wins_no_wr", int'(Ram_Wen), 0);
        do_cfg(2'd2, 5'd0, w, a, d, rdy);
        check("dis_cfg_addr", int'(a), 2);
        check("dis_cfg_wdata", int'(d), 0);
        check("dis_ready_back", int'(rdy), 1);
        check("dis_ram2", int'(ram[2]), 0);
        step();
        check("dis_alarm_cleared", int'(Alarm_Vec), 0);
        tick_scan(n);
        check("dis_scan_cycles", n, 8);
        check("dis_ram2_after", int'(ram[2]), 0);
        check("dis_alarm_after", int'(Alarm_Vec), 0);

        // two ticks during a 4-active-slot scan: one rescan, overrun
        do_reset();
        check("rst2_overrun", int'(Overrun), 0);
        for (int i = 0; i < 4; i++) do_cfg(2'(i), 5'd20, w, a, d, rdy);
        pulse_tick();
        check("ov_busy", int'(Busy), 1);
        repeat (3) step();
        pulse_tick();
        check("ov_first_pend", int'(Overrun), 0);
        repeat (2) step();
        pulse_tick();
        check("ov_second_drop", int'(Overrun), 1);
        repeat (80) step();
        check("ov_idle", int'(Busy), 0);
        for (int i = 0; i < 4; i++) check($sformatf("ov_ram%0d", i), int'(ram[i]), 18);
        check("ov_sticky", int'(Overrun), 1);

        // one tick during a scan: one rescan, no overrun
        do_reset();
        for (int i = 0; i < 4; i++) do_cfg(2'(i), 5'd20, w, a, d, rdy);
        pulse_tick();
        repeat (3) step();
        pulse_tick();
        repeat (80) step();
        for (int i = 0; i < 4; i++) check($sformatf("pend_ram%0d", i), int'(ram[i]), 18);
        check("pend_overrun", int'(Overrun), 0);

`ifdef MISSED_DOSE_CNT_EN
        // missed-dose counter saturation
        do_reset();
        do_cfg(2'd0, 5'd1, w, a, d, rdy);
        Miss_Sel = 2'd0;
        #1;
        check("miss_start", int'(Miss_Count), 0);
        repeat (5) tick_scan(n);
        check("miss_after5", int'(Miss_Count), 4);
        repeat (15) tick_scan(n);
        check("miss_sat", int'(Miss_Count), 15);
        do_cfg(2'd0, 5'd1, w, a, d, rdy);
        check("miss_cfg_clear", int'(Miss_Count), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
